multicycle_alu: RTL

//  Execution unit that consumes the 4-bit ALU_Operation code produced by the ALU control decoder.

---
 rtl/multicycle_alu.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_alu.sv
// Multicycle ALU: logic and add/sub ops finish in one cycle; shifts use a serial 1-bit/cycle shifter.
// Handshake is start_i/ready_o in, done_o pulse out, with every output driven straight from a flop.
module multicycle_alu #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [3:0]            ALU_Operation_i,
    input  logic [DATA_WIDTH-1:0] A_i,
    input  logic [DATA_WIDTH-1:0] B_i,
    output logic                  ready_o,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] ALU_Result_o,
    output logic                  Zero_o,
    output logic                  illegal_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] SH_SLL = 2'd0;
    localparam logic [1:0] SH_SRL = 2'd1;
    localparam logic [1:0] SH_SRA = 2'd2;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [DATA_WIDTH-1:0]  r_acc;
    logic [DATA_WIDTH-1:0]  w_acc_next;
    logic [SHAMT_WIDTH-1:0] r_count;
    logic [SHAMT_WIDTH-1:0] w_count_next;
    logic [1:0]             r_kind;
    logic [1:0]             w_kind_next;
    logic [DATA_WIDTH-1:0]  r_result;
    logic [DATA_WIDTH-1:0]  w_result_next;
    logic                   r_zero;
    logic                   w_zero_next;
    logic                   r_illegal;
    logic                   w_illegal_next;
    logic                   r_ready;
    logic                   r_done;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == 4'b0110) || (op == 4'b0111) || (op == 4'b1000);
    endfunction

    function automatic logic [1:0] shift_kind(input logic [3:0] op);
        case (op)
            4'b0110: return SH_SLL;
            4'b0111: return SH_SRL;
            default: return SH_SRA;
        endcase
    endfunction

    function automatic logic is_legal_op(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
            4'b0110, 4'b0111, 4'b1000, 4'b1001: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Single-cycle ops; unsupported codes yield zero.
    function automatic logic [DATA_WIDTH-1:0] alu_single(
        input logic [3:0]            op,
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b
    );
        case (op)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return a ^ b;
            4'b1001: return b;
            default: return '0;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_step(
        input logic [1:0]            kind,
        input logic [DATA_WIDTH-1:0] acc
    );
        logic signed [DATA_WIDTH-1:0] s_acc;
        s_acc = acc;
        case (kind)
            SH_SLL:  return acc << 1;
            SH_SRL:  return acc >> 1;
            default: return s_acc >>> 1;
        endcase
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_acc     <= '0;
            r_count   <= '0;
            r_kind    <= SH_SLL;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_illegal <= 1'b0;
            r_ready   <= 1'b1;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_acc     <= w_acc_next;
            r_count   <= w_count_next;
            r_kind    <= w_kind_next;
            r_result  <= w_result_next;
            r_zero    <= w_zero_next;
            r_illegal <= w_illegal_next;
            r_ready   <= (w_next_state == S_IDLE);
            r_done    <= (w_next_state == S_DONE);
        end
    end

    always_comb begin
        w_next_state   = r_state;
        w_acc_next     = r_acc;
        w_count_next   = r_count;
        w_kind_next    = r_kind;
        w_result_next  = r_result;
        w_zero_next    = r_zero;
        w_illegal_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    if (is_shift_op(ALU_Operation_i)) begin
                        w_acc_next   = A_i;
                        w_count_next = B_i[SHAMT_WIDTH-1:0];
                        w_kind_next  = shift_kind(ALU_Operation_i);
                        w_next_state = S_SHIFT;
                    end else begin
                        w_result_next  = alu_single(ALU_Operation_i, A_i, B_i);
                        w_zero_next    = (w_result_next == '0);
                        w_illegal_next = !is_legal_op(ALU_Operation_i);
                        w_next_state   = S_DONE;
                    end
                end
            end
            S_SHIFT: begin
                if (r_count != '0) begin
                    w_acc_next   = shift_step(r_kind, r_acc);
                    w_count_next = r_count - SHAMT_WIDTH'(1);
                end else begin
                    w_result_next = r_acc;
                    w_zero_next   = (r_acc == '0);
                    w_next_state  = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign ready_o      = r_ready;
    assign done_o       = r_done;
    assign ALU_Result_o = r_result;
    assign Zero_o       = r_zero;
    assign illegal_o    = r_illegal;

endmodule
